cla_addsub_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's fixed 4-bit combinational CLA.
- Operand split into GROUP-bit lookahead groups; one group resolved per pipeline stage, with group carry registered between stages.
- Adds subtract mode, valid/ready flow control with backpressure, and status flags.
- Used as the shared arithmetic unit in datapaths above it.

---
 rtl/cla_addsub_pipe.sv | 152 +++++++++++++++
 tb/tb_cla_addsub_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead adder/subtractor.
// The operand is split into GROUP-bit lookahead groups, and one group is
// resolved per stage (NSTAGE = WIDTH/GROUP stages). The carry out of each
// group is registered between stages. Operands that are not consumed yet
// travel forward with the beat, and finished low sum groups ride along to
// the output.
// Optional build macro CLA_SATURATE_EN: on signed overflow, sum is clamped
// to the signed limit. ovf and cout still report the raw adder values.
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = WIDTH / GROUP;

  // Per-stage state. Index NSTAGE-1 is the output register.
  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [WIDTH-1:0]  a_q [NSTAGE];
  logic [WIDTH-1:0]  b_q [NSTAGE];
  logic [WIDTH-1:0]  s_q [NSTAGE];
  logic              c_q [NSTAGE];
  logic [WIDTH-1:0]  a_d [NSTAGE];
  logic [WIDTH-1:0]  b_d [NSTAGE];
  logic [WIDTH-1:0]  s_d [NSTAGE];
  logic              c_d [NSTAGE];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              adv;

  // One global enable: the whole pipe moves together or holds together.
  // It depends only on the output handshake and never on in_valid.
  assign adv      = !vld_q[NSTAGE-1] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
    logic [WIDTH-1:0] ain, bin, sin, snew;
    logic             vin, c0;
    logic [GROUP-1:0] g, p;
    logic [GROUP:0]   c;
    logic             t, pp;

    if (k == 0) begin : g_in
      // Subtraction is done as A + ~B + ~borrow.
      assign ain = a;
      assign bin = sub ? ~b : b;
      assign c0  = sub ^ cin;
      assign sin = '0;
      assign vin = in_valid;
    end else begin : g_in
      assign ain = a_q[k-1];
      assign bin = b_q[k-1];
      assign c0  = c_q[k-1];
      assign sin = s_q[k-1];
      assign vin = vld_q[k-1];
    end

    // Group k: the carries are written out as flat sum-of-products
    // lookahead terms, so there is no ripple chain inside the group.
    always_comb begin
      g    = ain[k*GROUP +: GROUP] & bin[k*GROUP +: GROUP];
      p    = ain[k*GROUP +: GROUP] ^ bin[k*GROUP +: GROUP];
      c    = '0;
      t    = 1'b0;
      pp   = 1'b0;
      c[0] = c0;
      for (int i = 0; i < GROUP; i++) begin
        t  = g[i];
        pp = p[i];
        for (int j = i - 1; j >= 0; j--) begin
          t  = t | (pp & g[j]);
          pp = pp & p[j];
        end
        c[i+1] = t | (pp & c0);
      end
      snew = sin;
      snew[k*GROUP +: GROUP] = p ^ c[GROUP-1:0];
    end

    if (k == NSTAGE - 1) begin : g_fin
      logic [WIDTH-1:0] sfin;
      logic             ov;
      assign ov = c[GROUP] ^ c[GROUP-1];
`ifdef CLA_SATURATE_EN
      // The sign of A gives the overflow direction. A is still at hand
      // here, so the clamp costs no extra stage.
      assign sfin = !ov          ? snew :
                    ain[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign sfin = snew;
`endif
      assign s_d[k] = sfin;
      assign ovf_d  = ov;
      assign zero_d = (sfin == '0);
    end else begin : g_mid
      assign s_d[k] = snew;
    end

    assign a_d[k]   = ain;
    assign b_d[k]   = bin;
    assign c_d[k]   = c[GROUP];
    assign vld_d[k] = vin;
  end

  // All stages advance on adv. Reset clears every stage and the flags,
  // and it wins over any stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
      end
    end
  end

  assign out_valid = vld_q[NSTAGE-1];
  assign sum       = s_q[NSTAGE-1];
  assign cout      = c_q[NSTAGE-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: self-checking bench for cla_addsub_pipe in its default
// configuration (16-bit operands, 4-bit groups). A reference model uses plain
// integer arithmetic and feeds an in-order queue of expected results.
module tb_cla_addsub_pipe;

  localparam int W   = 16;
  localparam int LAT = 3;  // edges from the accept edge to out_valid

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  a, b;
  logic          cin, sub;
  logic          out_valid, out_ready;
  logic [W-1:0]  sum;
  logic          cout, ovf, zero;

  int            n_vec = 0;
  int            n_err = 0;
  int            hs_cnt = 0;
  logic [18:0]   exp_q[$];
  logic [W-1:0]  stream_sum[$];
  logic          rec = 1'b0;
  logic          hold_prev = 1'b0;
  logic [18:0]   held_bus;

  cla_addsub_pipe #(.WIDTH(W), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Result packing: {zero, ovf, cout, sum}.
  function automatic logic [18:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic sb);
    int ut, st;
    logic [W-1:0] r;
    logic co, ov;
    if (sb) begin
      ut = int'(x) - int'(y) - int'(ci);
      st = int'($signed(x)) - int'($signed(y)) - int'(ci);
      co = (ut >= 0);
    end else begin
      ut = int'(x) + int'(y) + int'(ci);
      st = int'($signed(x)) + int'($signed(y)) + int'(ci);
      co = (ut > 65535);
    end
    r  = ut[W-1:0];
    ov = (st > 32767) || (st < -32768);
`ifdef CLA_SATURATE_EN
    if (ov) r = (st > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {(r == '0), ov, co, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 8)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake,
  // check that held outputs stay stable, and flush on reset.
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'({zero, ovf, cout, sum}), 32'(held_bus));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sum", 32'(sum), 32'(e[15:0]));
          chk("cout", 32'(cout), 32'(e[16]));
          chk("ovf", 32'(ovf), 32'(e[17]));
          chk("zero", 32'(zero), 32'(e[18]));
          hs_cnt++;
          if (rec) stream_sum.push_back(sum);
        end
      end
      hold_prev = out_valid && !out_ready;
      held_bus  = {zero, ovf, cout, sum};
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Send one beat into an empty pipe and check latency and the literal result.
  task automatic one(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                     input logic sb, input logic [W-1:0] es, input logic ec,
                     input logic eo, input logic ez);
    int lat;
    out_ready = 1'b1; in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin cycle(); lat++; end
    chk("latency", 32'(lat), 32'(LAT));
    chk("dir_sum", 32'(sum), 32'(es));
    chk("dir_cout", 32'(cout), 32'(ec));
    chk("dir_ovf", 32'(ovf), 32'(eo));
    chk("dir_zero", 32'(zero), 32'(ez));
    cycle();
  endtask

  initial begin
    int i, hs0, gaps, cnt;
    logic acc, got_first;
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", 32'({cout, ovf, zero}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases.
    one(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    one(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
    one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
`ifdef CLA_SATURATE_EN
    one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
    one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
`else
    one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
`endif

    // Back-to-back stream with a 3-cycle output stall after the first result.
    rec = 1'b1; i = 0; hs0 = hs_cnt; gaps = 0; got_first = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (hs_cnt - hs0) < 8; cyc++) begin
      in_valid = (i < 8); a = W'(i); b = W'(i); cin = 1'b0; sub = 1'b0;
      #1;
      acc = in_valid && in_ready;
      cycle();
      if (acc) i++;
      if (got_first && !out_valid && (hs_cnt - hs0) < 8) gaps++;
      if (!got_first && out_valid) begin
        got_first = 1'b1;
        held = sum;
        out_ready = 1'b0;
        repeat (3) begin
          cycle();
          chk("stall_in_ready", 32'(in_ready), 32'd0);
          chk("stall_valid", 32'(out_valid), 32'd1);
          chk("stall_sum", 32'(sum), 32'(held));
        end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    rec = 1'b0;
    chk("stream_count", 32'(hs_cnt - hs0), 32'd8);
    chk("stream_gaps", 32'(gaps), 32'd0);
    for (int k = 0; k < 8; k++)
      if (k < stream_sum.size()) chk("stream_order", 32'(stream_sum[k]), 32'(2 * k));
    cycle();

    // Reset with three beats in flight: nothing may come out afterwards.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_sum", 32'(sum), 32'd0);
    chk("flush_flags", 32'({cout, ovf, zero}), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cnt = 0;
    repeat (8) begin cycle(); if (out_valid) cnt++; end
    chk("flush_none", 32'(cnt), 32'd0);

    // Random traffic with random bubbles and backpressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a = pick(); b = pick(); cin = 1'($urandom); sub = 1'($urandom);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
